// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder built around a single full-adder cell
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_a ^ i_b ^ i_c;
    assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_MSB_IN = CW'(WIDTH - 2);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-2:0] r_s_sh;
    logic             r_carry;
    logic             r_c_msb_in;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             w_fa_sum;
    logic             w_fa_cout;
    logic [WIDTH-1:0] w_s_next;

    full_adder u_fa (
        .i_a (r_a_sh[0]),
        .i_b (r_b_sh[0]),
        .i_c (r_carry),
        .o_s (w_fa_sum),
        .o_c (w_fa_cout)
    );

    // Partial sum after this bit; bit 0 drops off the shift register but lands in sum on the last bit.
    assign w_s_next = {w_fa_sum, r_s_sh};

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_nxt = ST_RUN;
            ST_RUN:  if (r_cnt == CNT_LAST) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sh     <= '0;
            r_b_sh     <= '0;
            r_s_sh     <= '0;
            r_carry    <= 1'b0;
            r_c_msb_in <= 1'b0;
            r_cnt      <= '0;
            r_sum      <= '0;
            r_cout     <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a_sh  <= a;
                        r_b_sh  <= b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    r_s_sh  <= w_s_next[WIDTH-1:1];
                    r_a_sh  <= {1'b0, r_a_sh[WIDTH-1:1]};
                    r_b_sh  <= {1'b0, r_b_sh[WIDTH-1:1]};
                    r_carry <= w_fa_cout;
                    r_cnt   <= r_cnt + CW'(1);
                    if (r_cnt == CNT_MSB_IN) begin
                        r_c_msb_in <= w_fa_cout;
                    end
                    if (r_cnt == CNT_LAST) begin
                        r_sum  <= w_s_next;
                        r_cout <= w_fa_cout;
                        r_ovf  <= r_c_msb_in ^ w_fa_cout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state == ST_RUN);
    assign done = (r_state == ST_DONE);
    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;
endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder against a cycle-level reference model
module tb_serial_adder;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             cin = 1'b0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int checks = 0;
    int errors = 0;
    logic cmp_en = 1'b0;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: {ovf, cout, sum} from plain integer arithmetic and the sign rule.
    function automatic logic [WIDTH+1:0] ref_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                                  input logic c);
        logic [WIDTH:0] full;
        logic           v;
        full = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
        v = (x[WIDTH-1] == y[WIDTH-1]) && (full[WIDTH-1] != x[WIDTH-1]);
        return {v, full};
    endfunction

    // Cycle-level model: phase 0 idle, 1 adding (m_left cycles to go), 2 result pulse.
    int               m_phase = 0;
    int               m_left = 0;
    logic [WIDTH+1:0] m_pend = '0;
    logic [WIDTH+1:0] m_res = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase <= 0;
            m_left  <= 0;
            m_res   <= '0;
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_pend  <= ref_add(a, b, cin);
                    m_left  <= WIDTH;
                    m_phase <= 1;
                end
                1: begin
                    m_left <= m_left - 1;
                    if (m_left == 1) begin
                        m_phase <= 2;
                        m_res   <= m_pend;
                    end
                end
                default: m_phase <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy", {31'd0, busy}, {31'd0, m_phase == 1});
            chk("done", {31'd0, done}, {31'd0, m_phase == 2});
            chk("sum", 32'(sum), 32'(m_res[WIDTH-1:0]));
            chk("cout", {31'd0, cout}, {31'd0, m_res[WIDTH]});
            chk("ovf", {31'd0, ovf}, {31'd0, m_res[WIDTH+1]});
        end
    end

    // Issue one add from IDLE; returns cycles from start to done and busy cycles seen.
    task automatic run_add(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v, input logic tc,
                           output int lat, output int nbusy);
        bit got;
        got = 0;
        lat = 0;
        nbusy = 0;
        @(negedge clk);
        a = ta;
        b = tb_v;
        cin = tc;
        start = 1'b1;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (n == 1) begin
                start = 1'b0;
                a = WIDTH'($urandom);
                b = WIDTH'($urandom);
                cin = 1'($urandom);
            end
            if (busy) nbusy++;
            if (done) begin
                lat = n;
                got = 1;
                break;
            end
        end
        if (!got) chk("done_timeout", 32'd0, 32'd1);
        @(negedge clk);
        chk("done_single_pulse", {31'd0, done}, 32'd0);
    endtask

    task automatic lit_add(input string name, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                           input logic tc, input logic [WIDTH-1:0] es, input logic ec, input logic ev);
        int lat;
        int nb;
        run_add(ta, tb_v, tc, lat, nb);
        chk({name, "_lat"}, 32'(lat), 32'(WIDTH + 1));
        chk({name, "_busy_cycles"}, 32'(nb), 32'(WIDTH));
        chk({name, "_sum"}, 32'(sum), 32'(es));
        chk({name, "_cout"}, {31'd0, cout}, {31'd0, ec});
        chk({name, "_ovf"}, {31'd0, ovf}, {31'd0, ev});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int nb;
        int prev_rise;
        int n_rise;
        logic prev_busy;

        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout_ovf", {30'd0, cout, ovf}, 32'd0);
        cmp_en = 1'b1;
        rst = 1'b0;

        lit_add("t1", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
        lit_add("t2a", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        lit_add("t2b", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        lit_add("t3a", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0);
        lit_add("t3b", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);

        // Start held high with operands changing every cycle.
        prev_busy = busy;
        prev_rise = -1;
        n_rise = 0;
        for (int n = 0; n < 45; n++) begin
            @(negedge clk);
            if (busy && !prev_busy) begin
                if (prev_rise >= 0) chk("t4_start_spacing", 32'(n - prev_rise), 32'(WIDTH + 2));
                prev_rise = n;
                n_rise++;
            end
            prev_busy = busy;
            start = 1'b1;
            a = WIDTH'($urandom);
            b = WIDTH'($urandom);
            cin = 1'($urandom);
        end
        chk("t4_accept_count", 32'(n_rise >= 3), 32'd1);
        start = 1'b0;
        for (int n = 0; n < 30 && (busy || done); n++) @(negedge clk);
        @(negedge clk);

        // Reset in the 4th RUN cycle aborts the add.
        a = 8'h12;
        b = 8'h34;
        cin = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_busy_before_rst", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_busy", {31'd0, busy}, 32'd0);
        chk("t5_done", {31'd0, done}, 32'd0);
        chk("t5_sum", 32'(sum), 32'd0);
        chk("t5_cout_ovf", {30'd0, cout, ovf}, 32'd0);
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            chk("t5_no_done", {31'd0, done}, 32'd0);
        end
        lit_add("t5", 8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0, 1'b0);

        for (int i = 0; i < 200; i++) begin
            run_add(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), lat, nb);
            chk("t6_lat", 32'(lat), 32'(WIDTH + 1));
        end

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
